// File: rtl/motor_drive_supervisor.sv
// Motor command conditioning: duty slew limit, bypass hysteresis,
// safe direction-reversal sequencing and a sticky stop-timeout fault.
module motor_drive_supervisor #(
    parameter int K_PWMRES        = 10,
    parameter int K_SPDWIDTH      = 15,
    parameter int K_RAMP_STEP     = 8,
    parameter int K_LOW_SPD_ON    = 2640,
    parameter int K_LOW_SPD_OFF   = 2900,
    parameter int K_STOP_SPD      = 16,
    parameter int K_STOP_SAMPLES  = 4,
    parameter int K_BRAKE_TIMEOUT = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [K_PWMRES-1:0]   i_pwm_command,
    input  logic [K_PWMRES-1:0]   i_param_pwm_max,
    input  logic                  i_brake_req,
    input  logic                  i_reverse_req,
    input  logic                  i_ramp_tick,
    input  logic [K_SPDWIDTH-1:0] i_speed,
    input  logic                  i_speed_valid,
    input  logic                  i_fault_clr,
    output logic [K_PWMRES-1:0]   o_pwm_cmd,
    output logic                  o_brake,
    output logic                  o_reverse,
    output logic                  o_bypass_power,
    output logic                  o_busy,
    output logic                  o_fault,
    output logic [2:0]            o_state
);

    localparam int SCW = $clog2(K_STOP_SAMPLES + 1);
    localparam int TOW = $clog2(K_BRAKE_TIMEOUT + 1);
    localparam int PW1 = K_PWMRES + 1;

    localparam logic [SCW-1:0]        STOP_N  = SCW'(K_STOP_SAMPLES);
    localparam logic [TOW-1:0]        TO_N    = TOW'(K_BRAKE_TIMEOUT);
    localparam logic [PW1-1:0]        STEP    = PW1'(K_RAMP_STEP);
    localparam logic [K_SPDWIDTH-1:0] SPD_ON  = K_SPDWIDTH'(K_LOW_SPD_ON);
    localparam logic [K_SPDWIDTH-1:0] SPD_OFF = K_SPDWIDTH'(K_LOW_SPD_OFF);
    localparam logic [K_SPDWIDTH-1:0] SPD_STP = K_SPDWIDTH'(K_STOP_SPD);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_RAMP_DOWN = 3'd1,
        S_BRAKE     = 3'd2,
        S_SWITCH    = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [K_PWMRES-1:0] pwm_q, pwm_d;
    logic                rev_q, rev_d;
    logic                byp_q, byp_d;
    logic                fault_q, fault_d;
    logic                pend_q, pend_d;
    logic [SCW-1:0]      stop_q, stop_d;
    logic [TOW-1:0]      to_q, to_d;

    logic [K_PWMRES-1:0] target;
    logic [PW1-1:0]      tgt_ext, pwm_ext, up_sum;
    logic                stopped, timed_out, mismatch;

    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        rev_d   = rev_q;
        byp_d   = byp_q;
        fault_d = fault_q;
        pend_d  = pend_q;
        stop_d  = stop_q;
        to_d    = to_q;

        target = '0;
        if (state_q == S_RUN) begin
            target = (i_pwm_command < i_param_pwm_max) ?
                     i_pwm_command : i_param_pwm_max;
        end
        tgt_ext   = {1'b0, target};
        pwm_ext   = {1'b0, pwm_q};
        up_sum    = pwm_ext + STEP;
        stopped   = (stop_q == STOP_N);
        timed_out = (to_q == TO_N);
        mismatch  = (i_reverse_req != rev_q);

        // Extended-width compares keep the step from wrapping at either rail
        if (i_ramp_tick) begin
            if (pwm_ext < tgt_ext) begin
                pwm_d = (up_sum > tgt_ext) ? target : up_sum[K_PWMRES-1:0];
            end else if (pwm_ext > tgt_ext) begin
                pwm_d = (pwm_ext < tgt_ext + STEP) ?
                        target : pwm_q - STEP[K_PWMRES-1:0];
            end
        end

        if (i_speed_valid) begin
            if (i_speed < SPD_ON) begin
                byp_d = 1'b1;
            end else if (i_speed >= SPD_OFF) begin
                byp_d = 1'b0;
            end
        end

        if (state_q == S_BRAKE) begin
            if (i_speed_valid) begin
                if (i_speed <= SPD_STP) begin
                    if (!stopped) stop_d = stop_q + 1'b1;
                end else begin
                    stop_d = '0;
                end
            end
            if (pend_q && i_ramp_tick && !timed_out) begin
                to_d = to_q + 1'b1;
            end
        end

        unique case (state_q)
            S_RUN: begin
                if (i_brake_req) begin
                    state_d = S_BRAKE;
                end else if (mismatch) begin
                    state_d = S_RAMP_DOWN;
                    pend_d  = 1'b1;
                end
            end
            S_RAMP_DOWN: begin
                if (!mismatch) begin
                    pend_d  = 1'b0;
                    state_d = i_brake_req ? S_BRAKE : S_RUN;
                end else if (i_brake_req || pwm_q == '0) begin
                    state_d = S_BRAKE;
                end
            end
            S_BRAKE: begin
                pwm_d = '0;
                if (pend_q && stopped) begin
                    state_d = S_SWITCH;
                end else if (pend_q && timed_out) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else if (!pend_q) begin
                    if (mismatch) begin
                        pend_d = 1'b1;
                    end else if (!i_brake_req) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_SWITCH: begin
                pwm_d   = '0;
                rev_d   = i_reverse_req;
                pend_d  = 1'b0;
                state_d = i_brake_req ? S_BRAKE : S_RUN;
            end
            S_FAULT: begin
                pwm_d = '0;
                if (i_fault_clr) begin
                    state_d = S_BRAKE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase

        // Every fresh entry into BRAKE starts stop and timeout counts anew
        if (state_d == S_BRAKE && state_q != S_BRAKE) begin
            stop_d = '0;
            to_d   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_RUN;
            pwm_q   <= '0;
            rev_q   <= 1'b0;
            byp_q   <= 1'b1;
            fault_q <= 1'b0;
            pend_q  <= 1'b0;
            stop_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_d;
            rev_q   <= rev_d;
            byp_q   <= byp_d;
            fault_q <= fault_d;
            pend_q  <= pend_d;
            stop_q  <= stop_d;
            to_q    <= to_d;
        end
    end

    assign o_pwm_cmd      = pwm_q;
    assign o_reverse      = rev_q;
    assign o_bypass_power = byp_q;
    assign o_fault        = fault_q;
    assign o_state        = state_q;
    assign o_brake        = (state_q == S_BRAKE) || (state_q == S_FAULT);
    assign o_busy         = pend_q || (state_q == S_SWITCH) ||
                            (state_q == S_FAULT);

endmodule

// File: tb/tb_motor_drive_supervisor.sv
// Directed sequencing checks plus a randomized ramp/hysteresis phase
// compared against an arithmetic reference model.
module tb_motor_drive_supervisor;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pwm_command, pwm_max;
    logic        brake_req, reverse_req, ramp_tick;
    logic [14:0] speed;
    logic        speed_valid, fault_clr;
    logic [9:0]  pwm_cmd;
    logic        brake, reverse, bypass, busy, fault;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_drive_supervisor dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pwm_command   (pwm_command),
        .i_param_pwm_max (pwm_max),
        .i_brake_req     (brake_req),
        .i_reverse_req   (reverse_req),
        .i_ramp_tick     (ramp_tick),
        .i_speed         (speed),
        .i_speed_valid   (speed_valid),
        .i_fault_clr     (fault_clr),
        .o_pwm_cmd       (pwm_cmd),
        .o_brake         (brake),
        .o_reverse       (reverse),
        .o_bypass_power  (bypass),
        .o_busy          (busy),
        .o_fault         (fault),
        .o_state         (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int gap);
        ramp_tick = 1'b1;
        @(negedge clk);
        ramp_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sample(input int v);
        speed       = 15'(v);
        speed_valid = 1'b1;
        @(negedge clk);
        speed_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pwm"}, 32'(pwm_cmd), 0);
        chk({tag, "_rev"}, 32'(reverse), 0);
        chk({tag, "_byp"}, 32'(bypass), 1);
        chk({tag, "_flt"}, 32'(fault), 0);
        chk({tag, "_st"}, 32'(state), 0);
        chk({tag, "_brk"}, 32'(brake), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_pwm, m_byp, tgt, exp_v;
        int spd_seq[5];
        int byp_seq[5];

        rst = 1'b1;
        pwm_command = 10'd0;
        pwm_max = 10'd1023;
        brake_req = 1'b0;
        reverse_req = 1'b0;
        ramp_tick = 1'b0;
        speed = 15'd0;
        speed_valid = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp up to 100 in steps of 8
        pwm_command = 10'd100;
        for (int k = 1; k <= 15; k++) begin
            tick(3);
            exp_v = (8 * k < 100) ? 8 * k : 100;
            chk($sformatf("ramp_up_%0d", k), 32'(pwm_cmd), 32'(exp_v));
        end
        pwm_max = 10'd50;
        for (int k = 1; k <= 8; k++) begin
            tick(3);
            exp_v = (100 - 8 * k > 50) ? 100 - 8 * k : 50;
            chk($sformatf("ramp_dn_%0d", k), 32'(pwm_cmd), 32'(exp_v));
        end
        pwm_command = 10'd40;
        tick(3);
        tick(3);
        chk("pwm_at_40", 32'(pwm_cmd), 40);

        // Reversal sequence
        reverse_req = 1'b1;
        @(negedge clk);
        chk("rev_rampdown_st", 32'(state), 1);
        chk("rev_busy", 32'(busy), 1);
        sample(500);
        for (int k = 1; k <= 5; k++) tick(3);
        chk("rev_pwm0", 32'(pwm_cmd), 0);
        chk("rev_brake_st", 32'(state), 2);
        chk("rev_brake_out", 32'(brake), 1);
        for (int k = 0; k < 4; k++) sample(10);
        chk("rev_switch_st", 32'(state), 3);
        chk("rev_switch_busy", 32'(busy), 1);
        chk("rev_switch_rev", 32'(reverse), 0);
        @(negedge clk);
        chk("rev_run_st", 32'(state), 0);
        chk("rev_run_rev", 32'(reverse), 1);
        chk("rev_run_busy", 32'(busy), 0);
        chk("rev_run_pwm", 32'(pwm_cmd), 0);
        for (int k = 1; k <= 3; k++) tick(3);
        chk("rev_reramp", 32'(pwm_cmd), 24);

        // Abort a reversal while ramping down
        reverse_req = 1'b0;
        @(negedge clk);
        chk("abort_rd_st", 32'(state), 1);
        reverse_req = 1'b1;
        @(negedge clk);
        chk("abort_run_st", 32'(state), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rev", 32'(reverse), 1);
        chk("abort_pwm", 32'(pwm_cmd), 24);

        // Stop timeout while speed stays high
        reverse_req = 1'b0;
        for (int i = 0; i < 200 && state != 3'd2; i++) tick(1);
        chk("to_enter_brake", 32'(state), 2);
        sample(500);
        for (int k = 0; k < 999; k++) tick(1);
        chk("to_999_st", 32'(state), 2);
        chk("to_999_flt", 32'(fault), 0);
        tick(1);
        chk("to_fault_st", 32'(state), 4);
        chk("to_fault", 32'(fault), 1);
        chk("to_fault_brk", 32'(brake), 1);
        chk("to_fault_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        chk("to_fault_sticky", 32'(fault), 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_brake_st", 32'(state), 2);
        chk("clr_fault", 32'(fault), 0);
        chk("clr_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) sample(0);
        chk("clr_switch_st", 32'(state), 3);
        @(negedge clk);
        chk("clr_run_st", 32'(state), 0);
        chk("clr_rev", 32'(reverse), 0);

        // Bypass hysteresis
        spd_seq = '{3000, 2700, 2600, 2800, 2900};
        byp_seq = '{0, 0, 1, 1, 0};
        for (int k = 0; k < 5; k++) begin
            sample(spd_seq[k]);
            chk($sformatf("hyst_%0d", spd_seq[k]), 32'(bypass),
                32'(byp_seq[k]));
        end
        speed = 15'd2700;
        @(negedge clk);
        @(negedge clk);
        chk("hyst_novalid", 32'(bypass), 0);
        speed = 15'd100;
        @(negedge clk);
        chk("hyst_novalid_low", 32'(bypass), 0);

        // Brake priority over reversal, then async reset in BRAKE
        brake_req = 1'b1;
        reverse_req = 1'b1;
        @(negedge clk);
        chk("prio_brake_st", 32'(state), 2);
        @(negedge clk);
        chk("prio_pending", 32'(busy), 1);
        chk("prio_still_brake", 32'(state), 2);
        #2 rst = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clk);
        brake_req = 1'b0;
        reverse_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Randomized ramp and hysteresis against the model
        m_pwm = 0;
        m_byp = 1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0)
                pwm_command = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 15) == 0)
                pwm_max = 10'($urandom_range(0, 1023));
            ramp_tick = ($urandom_range(0, 2) == 0);
            speed_valid = ($urandom_range(0, 3) == 0);
            speed = 15'($urandom_range(2400, 3200));
            @(negedge clk);
            if (ramp_tick) begin
                tgt = (pwm_command < pwm_max) ? int'(pwm_command)
                                              : int'(pwm_max);
                if (m_pwm < tgt)
                    m_pwm = (m_pwm + 8 > tgt) ? tgt : m_pwm + 8;
                else if (m_pwm > tgt)
                    m_pwm = (m_pwm - 8 < tgt) ? tgt : m_pwm - 8;
            end
            if (speed_valid) begin
                if (speed < 2640) m_byp = 1;
                else if (speed >= 2900) m_byp = 0;
            end
            chk($sformatf("rnd_pwm_%0d", c), 32'(pwm_cmd), 32'(m_pwm));
            chk($sformatf("rnd_byp_%0d", c), 32'(bypass), 32'(m_byp));
        end
        ramp_tick = 1'b0;
        speed_valid = 1'b0;
        chk("rnd_state_run", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
